// File: rtl/cpu2_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu2_ctrl_if
//  Purpose  : Instruction handshake and datapath control bundle between the
//             cpu2 control sequencer and its datapath / instruction source.
//  Revision : 1.0  initial release
// ============================================================================
interface cpu2_ctrl_if #(
  parameter int RETIRE_W = 16
);
  logic [31:0]         instr;
  logic                instr_valid;
  logic                instr_ready;
  logic                mem_ready;
  logic                ir_we;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic [31:0]         imm;
  logic                alu_src_imm;
  logic                mem_re;
  logic                mem_we;
  logic                mem_to_reg;
  logic                reg_we;
  logic                busy;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  // Sequencer side: consumes instructions, drives datapath controls
  modport master (
    input  instr, instr_valid, mem_ready,
    output instr_ready, ir_we, rs1, rs2, rd, imm, alu_src_imm,
           mem_re, mem_we, mem_to_reg, reg_we, busy, illegal, retired
  );

  // Datapath / instruction source side
  modport slave (
    output instr, instr_valid, mem_ready,
    input  instr_ready, ir_we, rs1, rs2, rd, imm, alu_src_imm,
           mem_re, mem_we, mem_to_reg, reg_we, busy, illegal, retired
  );
endinterface
`default_nettype wire

// File: rtl/cpu2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu2_ctrl
//  Purpose  : Multicycle control sequencer for the cpu2 datapath. Decodes
//             RV32I addi / lw / sw, steps FETCH-DECODE-EXEC-MEM-WB, traps on
//             unsupported encodings or memory timeout, counts retirements.
//  Revision : 1.0  initial release
// ============================================================================
module cpu2_ctrl #(
  parameter int RETIRE_W    = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  cpu2_ctrl_if.master bus
);

  // Wait counter only needs to reach MEM_TIMEOUT-1
  localparam int                WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit                TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_WORD    = 3'b010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e              state_q;
  logic [31:0]         ir_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [RETIRE_W-1:0] retired_q;

  logic is_addi;
  logic is_lw;
  logic is_sw;
  logic is_legal;
  logic [31:0] imm_i;
  logic [31:0] imm_s;

  // Instruction class decode from the latched IR
  assign is_addi  = (ir_q[6:0] == OPC_OP_IMM) && (ir_q[14:12] == F3_ADDI);
  assign is_lw    = (ir_q[6:0] == OPC_LOAD)   && (ir_q[14:12] == F3_WORD);
  assign is_sw    = (ir_q[6:0] == OPC_STORE)  && (ir_q[14:12] == F3_WORD);
  assign is_legal = is_addi | is_lw | is_sw;

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};

  // Sequencer: state, IR capture, memory wait counter and retire counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.instr_valid) begin
            ir_q    <= bus.instr;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          state_q <= is_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          // Counter starts fresh for every memory access
          wait_q  <= '0;
          state_q <= is_addi ? S_WB : S_MEM;
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (is_sw) begin
              retired_q <= retired_q + RETIRE_W'(1);
              state_q   <= S_FETCH;
            end else begin
              state_q   <= S_WB;
            end
          end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
            state_q <= S_TRAP;
          end else begin
            wait_q  <= wait_q + WAIT_W'(1);
          end
        end
        S_WB: begin
          retired_q <= retired_q + RETIRE_W'(1);
          state_q   <= S_FETCH;
        end
        S_TRAP: begin
          state_q <= S_TRAP;
        end
        default: begin
          state_q <= S_TRAP;
        end
      endcase
    end
  end

  // Controls decode from state and IR so reset drops every strobe at once
  assign bus.instr_ready = (state_q == S_FETCH);
  assign bus.ir_we       = bus.instr_valid & bus.instr_ready;
  assign bus.busy        = (state_q != S_FETCH) && (state_q != S_TRAP);
  assign bus.illegal     = (state_q == S_TRAP);
  assign bus.alu_src_imm = (state_q == S_EXEC) || (state_q == S_MEM);
  assign bus.mem_re      = (state_q == S_MEM) && is_lw;
  assign bus.mem_we      = (state_q == S_MEM) && is_sw;
  assign bus.mem_to_reg  = (state_q == S_WB) && is_lw;
  assign bus.reg_we      = (state_q == S_WB) && (ir_q[11:7] != 5'd0);

  assign bus.rs1     = ir_q[19:15];
  assign bus.rs2     = ir_q[24:20];
  assign bus.rd      = ir_q[11:7];
  assign bus.imm     = is_sw ? imm_s : imm_i;
  assign bus.retired = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu2_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu2_ctrl
//  Purpose  : Directed self-checking bench for cpu2_ctrl. A second instance
//             with a 3-bit retire counter shares the stimulus to show wrap.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu2_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cpu2_ctrl_if #(.RETIRE_W(16)) bus ();
  cpu2_ctrl_if #(.RETIRE_W(3))  bw  ();

  assign bw.instr       = bus.instr;
  assign bw.instr_valid = bus.instr_valid;
  assign bw.mem_ready   = bus.mem_ready;

  cpu2_ctrl #(.RETIRE_W(16), .MEM_TIMEOUT(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cpu2_ctrl #(.RETIRE_W(3), .MEM_TIMEOUT(8)) u_dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bw)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Snapshot of the last busy cycle of a run plus strobe statistics
  int          cycles;
  int          n_re;
  int          n_we;
  logic        s_reg_we;
  logic        s_m2r;
  logic [4:0]  s_rd;
  logic [4:0]  s_rs1;
  logic [4:0]  s_rs2;
  logic [31:0] s_imm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one instruction in FETCH, then follow it until FETCH or TRAP.
  // mem_ready stays low for the first wait_n memory cycles. Garbage with
  // instr_valid high is driven while busy; it must never be latched.
  task automatic run_instr(input logic [31:0] ins, input int wait_n);
    int mem_cyc;
    mem_cyc = 0;
    n_re    = 0;
    n_we    = 0;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    cycles = 1;
    bus.instr = ~ins;
    while (!bus.instr_ready && !bus.illegal && cycles <= 40) begin
      if (bus.mem_re) n_re++;
      if (bus.mem_we) n_we++;
      if (bus.mem_re || bus.mem_we) begin
        mem_cyc++;
        bus.mem_ready = (mem_cyc > wait_n);
      end else begin
        bus.mem_ready = 1'b1;
      end
      s_reg_we = bus.reg_we;
      s_m2r    = bus.mem_to_reg;
      s_rd     = bus.rd;
      s_rs1    = bus.rs1;
      s_rs2    = bus.rs2;
      s_imm    = bus.imm;
      @(posedge clk); #1;
      cycles++;
    end
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.mem_ready   = 1'b1;
  endtask

  // Hard stop in case the stimulus itself stalls
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.mem_ready   = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_illegal",     32'(bus.illegal),     32'd0);
    check("rst_retired",     32'(bus.retired),     32'd0);
    check("rst_strobes", 32'({bus.mem_re, bus.mem_we, bus.reg_we, bus.alu_src_imm, bus.mem_to_reg}), 32'd0);
    check("rst_imm",         bus.imm,              32'd0);
    check("rst_ir_we_idle",  32'(bus.ir_we),       32'd0);
    bus.instr_valid = 1'b1;
    #1;
    check("fetch_ir_we",     32'(bus.ir_we),       32'd1);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    // ---------------- addi x30, x0, 99 ----------------
    run_instr(32'h06300F13, 0);
    check("addi_cycles",  32'(cycles),   32'd4);
    check("addi_reg_we",  32'(s_reg_we), 32'd1);
    check("addi_rd",      32'(s_rd),     32'd30);
    check("addi_rs1",     32'(s_rs1),    32'd0);
    check("addi_imm",     s_imm,         32'd99);
    check("addi_m2r",     32'(s_m2r),    32'd0);
    check("addi_retired", 32'(bus.retired), 32'd1);

    // ---------------- sw x30, 0(x0) ----------------
    run_instr(32'h01E02023, 0);
    check("sw_cycles",  32'(cycles),   32'd4);
    check("sw_we_cnt",  32'(n_we),     32'd1);
    check("sw_re_cnt",  32'(n_re),     32'd0);
    check("sw_rs2",     32'(s_rs2),    32'd30);
    check("sw_rs1",     32'(s_rs1),    32'd0);
    check("sw_imm",     s_imm,         32'd0);
    check("sw_retired", 32'(bus.retired), 32'd2);

    // ---------------- lw x31, 0(x0), 3 wait cycles ----------------
    run_instr(32'h00002F83, 3);
    check("lw_cycles",  32'(cycles),   32'd8);
    check("lw_re_cnt",  32'(n_re),     32'd4);
    check("lw_reg_we",  32'(s_reg_we), 32'd1);
    check("lw_rd",      32'(s_rd),     32'd31);
    check("lw_m2r",     32'(s_m2r),    32'd1);
    check("lw_retired", 32'(bus.retired), 32'd3);
    check("lw_retired_w", 32'(bw.retired), 32'd3);

    // ---------------- sw x5, -4(x2): negative S-type immediate ----------------
    run_instr(32'hFE512E23, 0);
    check("swneg_cycles", 32'(cycles), 32'd4);
    check("swneg_imm",    s_imm,       32'hFFFF_FFFC);
    check("swneg_rs2",    32'(s_rs2),  32'd5);
    check("swneg_rs1",    32'(s_rs1),  32'd2);
    check("swneg_retired", 32'(bus.retired), 32'd4);

    // ---------------- lw with mem_ready never asserted ----------------
    run_instr(32'h00002F83, 1000);
    check("to_re_cnt",      32'(n_re),            32'd8);
    check("to_illegal",     32'(bus.illegal),     32'd1);
    check("to_mem_re",      32'(bus.mem_re),      32'd0);
    check("to_retired",     32'(bus.retired),     32'd4);
    check("to_instr_ready", 32'(bus.instr_ready), 32'd0);
    bus.instr       = 32'h06300F13;
    bus.instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("trap_sticky",      32'(bus.illegal),     32'd1);
    check("trap_instr_ready", 32'(bus.instr_ready), 32'd0);
    check("trap_busy",        32'(bus.busy),        32'd0);
    bus.instr_valid = 1'b0;

    // ---------------- reset clears trap ----------------
    rst = 1'b0;
    #2;
    check("trst_illegal",     32'(bus.illegal),     32'd0);
    check("trst_instr_ready", 32'(bus.instr_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // ---------------- addi x0, x0, 1 ----------------
    run_instr(32'h00100013, 0);
    check("rd0_cycles",  32'(cycles),      32'd4);
    check("rd0_reg_we",  32'(s_reg_we),    32'd0);
    check("rd0_retired", 32'(bus.retired), 32'd1);

    // ---------------- asynchronous abort in MEM ----------------
    bus.mem_ready   = 1'b0;
    bus.instr       = 32'h00002F83;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_pre_mem_re", 32'(bus.mem_re), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("abort_mem_re",      32'(bus.mem_re),      32'd0);
    check("abort_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("abort_retired",     32'(bus.retired),     32'd0);
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;

    // ---------------- retire counter wrap on the 3-bit instance ----------------
    for (int k = 1; k <= 8; k++) begin
      run_instr(32'h00100093, 0);
      check("wrap_retired",   32'(bus.retired), 32'(k));
      check("wrap_retired_w", 32'(bw.retired),  32'(k % 8));
    end

    // ---------------- unsupported encoding (add) ----------------
    run_instr(32'h00000033, 0);
    check("ill_cycles",  32'(cycles),      32'd2);
    check("ill_illegal", 32'(bus.illegal), 32'd1);
    check("ill_retired", 32'(bus.retired), 32'd8);
    rst = 1'b0;
    #2;
    check("irst_instr_ready", 32'(bus.instr_ready), 32'd1);
    check("irst_illegal",     32'(bus.illegal),     32'd0);
    check("irst_retired",     32'(bus.retired),     32'd0);
    check("irst_retired_w",   32'(bw.retired),      32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
